// File: rtl/can_pkg.sv
// Shared types, segment limits and config clamps for the CAN bit-timing sequencer.
package can_pkg;

    typedef enum logic [1:0] {
        BT_IDLE = 2'd0,
        BT_SYNC = 2'd1,
        BT_SEG1 = 2'd2,
        BT_SEG2 = 2'd3
    } bt_state_t;

    localparam int unsigned SEG1_MIN = 2;
    localparam int unsigned SEG1_MAX = 16;
    localparam int unsigned SEG2_MIN = 2;
    localparam int unsigned SEG2_MAX = 8;
    localparam int unsigned SJW_MAX  = 4;

    function automatic logic [4:0] clamp_seg1(input logic [4:0] v);
        if (v < 5'(SEG1_MIN)) return 5'(SEG1_MIN);
        if (v > 5'(SEG1_MAX)) return 5'(SEG1_MAX);
        return v;
    endfunction

    function automatic logic [3:0] clamp_seg2(input logic [3:0] v);
        if (v < 4'(SEG2_MIN)) return 4'(SEG2_MIN);
        if (v > 4'(SEG2_MAX)) return 4'(SEG2_MAX);
        return v;
    endfunction

endpackage

// File: rtl/can_clk_gen.sv
// Time-quantum prescaler: one-cycle pulse every DIVISOR enabled clocks; count holds while disabled.
module can_clk_gen #(
    parameter int unsigned DIVISOR = 200
) (
    input  logic clock_in_i,
    input  logic reset_i,
    input  logic en_i,
    output logic pulse_o,
    output logic clk_o
);
    localparam int unsigned CntW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(DIVISOR - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(DIVISOR / 2);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clk_q, clk_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
        clk_d = (cnt_d < CntHalf);
    end

    always_ff @(posedge clock_in_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign pulse_o = en_i && (cnt_q == CntMax);
    assign clk_o   = clk_q;

endmodule

// File: rtl/can_bit_timing_ctrl.sv
// CAN bit-timing sequencer: steps each bit through SYNC/SEG1/SEG2 on tq ticks, with hard sync
// and SJW-limited resynchronisation on recessive-to-dominant RX edges.
module can_bit_timing_ctrl
    import can_pkg::*;
#(
    parameter int unsigned TQ_DIVISOR = 200
) (
    input  logic       clock_in_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       rx_i,
    input  logic [4:0] seg1_i,
    input  logic [3:0] seg2_i,
    input  logic [1:0] sjw_i,
    input  logic       hard_sync_en_i,
    output logic       tq_tick_o,
    output logic       bit_start_o,
    output logic       sample_point_o,
    output logic       sampled_bit_o,
    output logic [1:0] state_o
);
    logic tq_pulse, tq_clk_unused, tq_tick;

    can_clk_gen #(.DIVISOR(TQ_DIVISOR)) u_tq_gen (
        .clock_in_i(clock_in_i),
        .reset_i   (reset_i),
        .en_i      (en_i),
        .pulse_o   (tq_pulse),
        .clk_o     (tq_clk_unused)
    );

    assign tq_tick = tq_pulse & en_i;

    bt_state_t  state_q, state_d;
    logic [4:0] tq_cnt_q, tq_cnt_d;
    logic [4:0] seg1_eff_q, seg1_eff_d;
    logic [3:0] seg2_eff_q, seg2_eff_d;
    logic [2:0] sjw_eff_q, sjw_eff_d;
    logic       edge_pend_q, edge_pend_d, edge_used_q, edge_used_d;
    logic       bit_start_q, bit_start_d, sample_point_q, sample_point_d;
    logic       sampled_bit_q, sampled_bit_d;
    logic       rx_meta_q, rx_sync_q, rx_prev_q;

    logic [4:0] seg1_cl;
    logic [3:0] seg2_cl;
    logic [2:0] sjw_cl;
    logic       edge_act, do_sync, latch_cfg;
    logic [5:0] seg1_len, seg1_adj;
    logic [3:0] seg2_len, phase_err;

    assign seg1_cl = clamp_seg1(seg1_i);
    assign seg2_cl = clamp_seg2(seg2_i);
    assign sjw_cl  = {1'b0, sjw_i} + 3'd1;

    always_comb begin
        state_d        = state_q;
        tq_cnt_d       = tq_cnt_q;
        seg1_eff_d     = seg1_eff_q;
        seg2_eff_d     = seg2_eff_q;
        sjw_eff_d      = sjw_eff_q;
        edge_used_d    = edge_used_q;
        sampled_bit_d  = sampled_bit_q;
        bit_start_d    = 1'b0;
        sample_point_d = 1'b0;
        edge_pend_d    = edge_pend_q | (rx_prev_q & ~rx_sync_q);
        edge_act       = 1'b0;
        do_sync        = 1'b0;
        latch_cfg      = 1'b0;
        seg1_len       = {1'b0, seg1_eff_q};
        seg1_adj       = '0;
        seg2_len       = seg2_eff_q;
        phase_err      = '0;

        if (!en_i) begin
            state_d     = BT_IDLE;
            tq_cnt_d    = '0;
            edge_pend_d = 1'b0;
        end else if (state_q == BT_IDLE) begin
            edge_pend_d = 1'b0;
            if (tq_tick) begin
                state_d     = BT_SYNC;
                tq_cnt_d    = '0;
                bit_start_d = 1'b1;
                latch_cfg   = 1'b1;
                edge_used_d = 1'b0;
            end
        end else if (tq_tick) begin
            // An edge detected in the same cycle as the tick still belongs to the ending tq.
            edge_act    = edge_pend_d & ~edge_used_q;
            edge_pend_d = 1'b0;
            if (edge_act) begin
                edge_used_d = 1'b1;
                if (hard_sync_en_i) begin
                    do_sync = 1'b1;
                end else if (state_q == BT_SEG1) begin
                    seg1_adj = {1'b0, tq_cnt_q} + 6'd1;
                    if (seg1_adj > {3'b0, sjw_eff_q}) seg1_adj = {3'b0, sjw_eff_q};
                    seg1_len = seg1_len + seg1_adj;
                end else if (state_q == BT_SEG2) begin
                    phase_err = seg2_eff_q - tq_cnt_q[3:0];
                    if (phase_err <= {1'b0, sjw_eff_q}) do_sync = 1'b1;
                    else seg2_len = seg2_eff_q - {1'b0, sjw_eff_q};
                end
            end

            if (do_sync) begin
                // The edge tq stands in for SYNC, so the new bit resumes directly in SEG1.
                state_d     = BT_SEG1;
                tq_cnt_d    = '0;
                bit_start_d = 1'b1;
                latch_cfg   = 1'b1;
            end else begin
                unique case (state_q)
                    BT_SYNC: begin
                        state_d  = BT_SEG1;
                        tq_cnt_d = '0;
                    end
                    BT_SEG1: begin
                        seg1_eff_d = seg1_len[4:0];
                        if ({1'b0, tq_cnt_q} == seg1_len - 6'd1) begin
                            state_d        = BT_SEG2;
                            tq_cnt_d       = '0;
                            sample_point_d = 1'b1;
                            sampled_bit_d  = rx_sync_q;
                        end else begin
                            tq_cnt_d = tq_cnt_q + 5'd1;
                        end
                    end
                    BT_SEG2: begin
                        seg2_eff_d = seg2_len;
                        if (tq_cnt_q == {1'b0, seg2_len} - 5'd1) begin
                            state_d     = BT_SYNC;
                            tq_cnt_d    = '0;
                            bit_start_d = 1'b1;
                            latch_cfg   = 1'b1;
                            edge_used_d = 1'b0;
                        end else begin
                            tq_cnt_d = tq_cnt_q + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (latch_cfg) begin
            seg1_eff_d = seg1_cl;
            seg2_eff_d = seg2_cl;
            sjw_eff_d  = sjw_cl;
        end
    end

    always_ff @(posedge clock_in_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= BT_IDLE;
            tq_cnt_q       <= '0;
            seg1_eff_q     <= 5'(SEG1_MIN);
            seg2_eff_q     <= 4'(SEG2_MIN);
            sjw_eff_q      <= 3'd1;
            edge_pend_q    <= 1'b0;
            edge_used_q    <= 1'b0;
            bit_start_q    <= 1'b0;
            sample_point_q <= 1'b0;
            sampled_bit_q  <= 1'b1;
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            rx_prev_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            tq_cnt_q       <= tq_cnt_d;
            seg1_eff_q     <= seg1_eff_d;
            seg2_eff_q     <= seg2_eff_d;
            sjw_eff_q      <= sjw_eff_d;
            edge_pend_q    <= edge_pend_d;
            edge_used_q    <= edge_used_d;
            bit_start_q    <= bit_start_d;
            sample_point_q <= sample_point_d;
            sampled_bit_q  <= sampled_bit_d;
            rx_meta_q      <= rx_i;
            rx_sync_q      <= rx_meta_q;
            rx_prev_q      <= rx_sync_q;
        end
    end

    assign tq_tick_o      = tq_tick;
    assign bit_start_o    = bit_start_q;
    assign sample_point_o = sample_point_q;
    assign sampled_bit_o  = sampled_bit_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_can_bit_timing_ctrl.sv
// Bench for can_bit_timing_ctrl: bit/sample timing vectors, random vectors against an arithmetic
// bit-length model, and hand sequences for hard sync, sampling, reset, enable and config changes.
module tb_can_bit_timing_ctrl;
    import can_pkg::*;

    localparam int Div = 4;

    logic       clk = 1'b0;
    logic       rst, en, rx, hs;
    logic [4:0] seg1;
    logic [3:0] seg2;
    logic [1:0] sjw;
    logic       tq_tick_o, bit_start_o, sample_point_o, sampled_bit_o;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    can_bit_timing_ctrl #(.TQ_DIVISOR(Div)) dut (
        .clock_in_i    (clk),
        .reset_i       (rst),
        .en_i          (en),
        .rx_i          (rx),
        .seg1_i        (seg1),
        .seg2_i        (seg2),
        .sjw_i         (sjw),
        .hard_sync_en_i(hs),
        .tq_tick_o     (tq_tick_o),
        .bit_start_o   (bit_start_o),
        .sample_point_o(sample_point_o),
        .sampled_bit_o (sampled_bit_o),
        .state_o       (state_o)
    );

    typedef struct {
        int s1; int s2; int sjw; int hs; int seg; int k;
        int len; int sp; int nxt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int bs_q[$];
    int sp_q[$];

    // Strobe timestamps, sampled 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (bit_start_o) bs_q.push_back(cyc);
        if (sample_point_o) sp_q.push_back(cyc);
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic wait_bs(input int n, input string name);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (bs_q.size() >= n) return;
        end
        check({name, "_timeout"}, bs_q.size(), n);
    endtask

    task automatic wait_sp(input int n, input string name);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (sp_q.size() >= n) return;
        end
        check({name, "_timeout"}, sp_q.size(), n);
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Bit length, sample offset after the following bit start, and the length of that next bit,
    // derived from tq counts of the CAN segments.
    function automatic void model(input int s1i, input int s2i, input int sjwi, input int hsi,
                                  input int seg, input int k,
                                  output int len, output int sp, output int nxt);
        int s1, s2, j, p;
        bit resync;
        s1 = clamp(s1i, 2, 16);
        s2 = clamp(s2i, 2, 8);
        j = sjwi + 1;
        resync = 1'b0;
        len = 1 + s1 + s2;
        p = (seg == 1) ? 1 + k : 1 + s1 + k;
        if (seg != 0 && hsi != 0) begin
            len = p + 1;
            resync = 1'b1;
        end else if (seg == 1) begin
            len += (k + 1 < j) ? k + 1 : j;
        end else if (seg == 2) begin
            if (s2 - k <= j) begin
                len = p + 1;
                resync = 1'b1;
            end else begin
                len -= j;
            end
        end
        sp  = Div * (resync ? s1 : 1 + s1);
        nxt = Div * (resync ? s1 + s2 : 1 + s1 + s2);
        len = Div * len;
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        int b1, b2, b3, p, spa;
        @(negedge clk);
        seg1 = 5'(v.s1);
        seg2 = 4'(v.s2);
        sjw  = 2'(v.sjw);
        hs   = v.hs[0];
        rx   = 1'b1;
        bs_q.delete();
        sp_q.delete();
        wait_bs(2, name);
        b1 = bs_q[1];
        if (v.seg != 0) begin
            p = (v.seg == 1) ? 1 + v.k : 1 + clamp(v.s1, 2, 16) + v.k;
            repeat (Div * p) @(negedge clk);
            rx = 1'b0;
            repeat (6) @(negedge clk);
            rx = 1'b1;
        end
        wait_bs(4, name);
        b2 = bs_q[2];
        b3 = bs_q[3];
        spa = -1;
        foreach (sp_q[i]) if (spa < 0 && sp_q[i] > b2) spa = sp_q[i] - b2;
        check({name, "_len"}, b2 - b1, v.len);
        check({name, "_sp"}, spa, v.sp);
        check({name, "_next"}, b3 - b2, v.nxt);
    endtask

    vec_t tbl[9];
    vec_t rv;
    int   b0, n;

    initial begin
        tbl[0] = '{5, 3, 0, 0, 0, 0, 36, 24, 36};
        tbl[1] = '{5, 3, 0, 0, 1, 1, 40, 24, 36};
        tbl[2] = '{5, 3, 1, 0, 2, 2, 36, 20, 32};
        tbl[3] = '{5, 3, 1, 0, 2, 0, 28, 24, 36};
        tbl[4] = '{5, 3, 0, 1, 2, 1, 32, 20, 32};
        tbl[5] = '{0, 15, 3, 0, 0, 0, 44, 12, 44};
        tbl[6] = '{31, 0, 0, 0, 0, 0, 76, 68, 76};
        tbl[7] = '{5, 3, 3, 0, 1, 2, 48, 24, 36};
        tbl[8] = '{5, 8, 0, 0, 2, 1, 52, 24, 56};

        rst = 1'b0; en = 1'b0; rx = 1'b1; hs = 1'b0;
        seg1 = 5'd5; seg2 = 4'd3; sjw = 2'd0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", int'(state_o), int'(BT_IDLE));
        check("rst_bit_start", int'(bit_start_o), 0);
        check("rst_sample_point", int'(sample_point_o), 0);
        check("rst_sampled_bit", int'(sampled_bit_o), 1);
        check("rst_tq_tick", int'(tq_tick_o), 0);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;

        for (int i = 0; i < 9; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        for (int r = 0; r < 20; r++) begin
            rv.s1  = int'($urandom_range(0, 31));
            rv.s2  = int'($urandom_range(0, 15));
            rv.sjw = int'($urandom_range(0, 3));
            rv.hs  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            rv.seg = int'($urandom_range(0, 2));
            if (rv.seg == 1) rv.k = int'($urandom_range(0, clamp(rv.s1, 2, 16) - 1));
            else if (rv.seg == 2) rv.k = int'($urandom_range(0, clamp(rv.s2, 2, 8) - 1));
            else rv.k = 0;
            model(rv.s1, rv.s2, rv.sjw, rv.hs, rv.seg, rv.k, rv.len, rv.sp, rv.nxt);
            run_vec($sformatf("rnd%0d", r), rv);
        end

        // Hard sync mid-SEG2, then a second edge in the resynchronised bit must be ignored.
        @(negedge clk);
        seg1 = 5'd5; seg2 = 4'd3; sjw = 2'd0; hs = 1'b1;
        bs_q.delete();
        wait_bs(2, "hs2");
        repeat (Div * 7) @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        wait_bs(4, "hs2");
        check("hs2_sync_len", bs_q[2] - bs_q[1], 32);
        check("hs2_ignored_len", bs_q[3] - bs_q[2], 32);
        hs = 1'b0;

        // Dominant RX across the sample point; the edge lands in SYNC so timing is unchanged.
        bs_q.delete();
        wait_bs(1, "samp");
        b0 = bs_q[0];
        rx = 1'b0;
        sp_q.delete();
        wait_sp(1, "samp");
        check("samp_offset", sp_q[0] - b0, 24);
        check("samp_bit0", int'(sampled_bit_o), 0);
        rx = 1'b1;

        // Asynchronous reset mid-SEG1.
        bs_q.delete();
        wait_bs(1, "mid_rst");
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_state", int'(state_o), int'(BT_IDLE));
        check("mid_rst_sampled", int'(sampled_bit_o), 1);
        check("mid_rst_strobes", int'({bit_start_o, sample_point_o, tq_tick_o}), 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("en_low_idle", int'(state_o), int'(BT_IDLE));
        en = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bit_start_o) begin
                n = i;
                break;
            end
        end
        check("en_rise_start", int'(n >= 1 && n <= 4), 1);

        // Enable dropped mid-bit: IDLE next cycle, no strobes while low.
        repeat (10) @(negedge clk);
        en = 1'b0;
        bs_q.delete();
        sp_q.delete();
        @(negedge clk);
        check("en_drop_state", int'(state_o), int'(BT_IDLE));
        repeat (40) @(negedge clk);
        check("en_drop_strobes", bs_q.size() + sp_q.size(), 0);
        en = 1'b1;

        // Mid-bit seg1 change takes effect at the next bit.
        bs_q.delete();
        wait_bs(2, "cfg");
        repeat (8) @(negedge clk);
        seg1 = 5'd8;
        wait_bs(4, "cfg");
        check("cfg_cur_len", bs_q[2] - bs_q[1], 36);
        check("cfg_next_len", bs_q[3] - bs_q[2], 48);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
